// File: rtl/morph_window_ctrl_if.sv
// Stream-side bundle for the morphology window sequencer.
// master drives pixels in and observes the line-buffer controls.
interface morph_window_ctrl_if #(
    parameter int DW = 10
);
    logic          iFVAL;
    logic          iDVAL;
    logic [DW-1:0] iDATA;
    logic [1:0]    iMODE;
    logic          oCLKEN;
    logic [DW-1:0] oDATA;
    logic [1:0]    oMODE;
    logic          oWVAL;
    logic [9:0]    oX;
    logic [9:0]    oY;
    logic          oBORDER;
    logic          oSOF;
    logic          oBUSY;
    logic          oERR;

    modport master (
        output iFVAL, iDVAL, iDATA, iMODE,
        input  oCLKEN, oDATA, oMODE, oWVAL,
        input  oX, oY, oBORDER, oSOF, oBUSY, oERR
    );

    modport slave (
        input  iFVAL, iDVAL, iDATA, iMODE,
        output oCLKEN, oDATA, oMODE, oWVAL,
        output oX, oY, oBORDER, oSOF, oBUSY, oERR
    );
endinterface

// File: rtl/morph_window_ctrl.sv
// 3x3 morphology line-buffer sequencer: position tracking,
// end-of-frame pad flush, window-centre and border flags.
module morph_window_ctrl #(
    parameter int            H_ACTIVE  = 640,
    parameter int            V_ACTIVE  = 480,
    parameter int            DW        = 10,
    parameter logic [DW-1:0] PAD_VALUE = 10'h3FF
) (
    input logic                iCLK,
    input logic                iRST_N,
    morph_window_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_FLUSH
    } state_t;

    localparam logic [9:0]  XL = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  YL = 10'(V_ACTIVE - 1);
    localparam logic [10:0] FL = 11'(H_ACTIVE);

    state_t        r_state, w_state;
    logic          r_fval;
    logic [9:0]    r_in_x, w_in_x;
    logic [9:0]    r_in_y, w_in_y;
    logic [9:0]    r_cx, w_cx;
    logic [9:0]    r_cy, w_cy;
    logic          r_primed, w_primed;
    logic          r_cdone, w_cdone;
    logic [10:0]   r_fcnt, w_fcnt;
    logic          r_clken, w_clken;
    logic [DW-1:0] r_data, w_data;
    logic [1:0]    r_mode, w_mode;
    logic          r_wval, w_wval;
    logic [9:0]    r_x, w_x;
    logic [9:0]    r_y, w_y;
    logic          r_border, w_border;
    logic          r_sof, w_sof;
    logic          r_busy, w_busy;
    logic          r_err, w_err;
    logic          w_shift;
    logic          w_restart;
    logic          w_rise;
    logic          w_fall;
    logic          w_last;

    assign w_rise = bus.iFVAL & ~r_fval;
    assign w_fall = ~bus.iFVAL & r_fval;
    assign w_last = (r_in_x == XL) && (r_in_y == YL);

    always_comb begin
        w_state   = r_state;
        w_in_x    = r_in_x;
        w_in_y    = r_in_y;
        w_cx      = r_cx;
        w_cy      = r_cy;
        w_primed  = r_primed;
        w_cdone   = r_cdone;
        w_fcnt    = r_fcnt;
        w_clken   = 1'b0;
        w_data    = r_data;
        w_mode    = r_mode;
        w_wval    = 1'b0;
        w_x       = r_x;
        w_y       = r_y;
        w_border  = r_border;
        w_sof     = 1'b0;
        w_err     = 1'b0;
        w_shift   = 1'b0;
        w_restart = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_restart = w_rise;
            end
            S_ACTIVE: begin
                // a falling FVAL only carries the final pixel
                w_shift = bus.iDVAL & ~(w_fall & ~w_last);
                if (w_shift) w_data = bus.iDATA;
                if (w_rise) begin
                    w_restart = 1'b1;
                    w_err     = 1'b1;
                end else if (w_fall && !w_shift) begin
                    w_state = S_IDLE;
                    w_err   = 1'b1;
                end else if (w_shift && w_last) begin
                    w_state = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_err = bus.iDVAL | w_rise;
                if (w_rise) begin
                    w_restart = 1'b1;
                end else begin
                    w_shift = 1'b1;
                    w_data  = PAD_VALUE;
                    if (r_fcnt == FL) w_state = S_IDLE;
                    else w_fcnt = r_fcnt + 11'd1;
                end
            end
            default: w_state = S_IDLE;
        endcase

        if (w_shift) begin
            w_clken = 1'b1;
            if (r_state == S_ACTIVE) begin
                if (r_in_x == XL) begin
                    w_in_x   = 10'd0;
                    w_in_y   = r_in_y + 10'd1;
                    w_primed = 1'b1;
                end else begin
                    w_in_x = r_in_x + 10'd1;
                end
            end
            // centre trails the input by one full line
            if (r_primed && !r_cdone) begin
                w_wval   = 1'b1;
                w_x      = r_cx;
                w_y      = r_cy;
                w_border = (r_cx == 10'd0) || (r_cx == XL) ||
                           (r_cy == 10'd0) || (r_cy == YL);
                if (r_cx == XL) begin
                    w_cx    = 10'd0;
                    w_cy    = r_cy + 10'd1;
                    w_cdone = (r_cy == YL);
                end else begin
                    w_cx = r_cx + 10'd1;
                end
            end
        end

        if (w_restart || w_state == S_IDLE) begin
            w_in_x   = 10'd0;
            w_in_y   = 10'd0;
            w_cx     = 10'd0;
            w_cy     = 10'd0;
            w_primed = 1'b0;
            w_cdone  = 1'b0;
            w_fcnt   = 11'd0;
        end
        if (w_restart) begin
            w_state = S_ACTIVE;
            w_sof   = 1'b1;
            w_mode  = (bus.iMODE == 2'd3) ? 2'd0 : bus.iMODE;
        end
        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state  <= S_IDLE;
            r_fval   <= 1'b0;
            r_in_x   <= 10'd0;
            r_in_y   <= 10'd0;
            r_cx     <= 10'd0;
            r_cy     <= 10'd0;
            r_primed <= 1'b0;
            r_cdone  <= 1'b0;
            r_fcnt   <= 11'd0;
            r_clken  <= 1'b0;
            r_data   <= PAD_VALUE;
            r_mode   <= 2'd0;
            r_wval   <= 1'b0;
            r_x      <= 10'd0;
            r_y      <= 10'd0;
            r_border <= 1'b0;
            r_sof    <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_fval   <= bus.iFVAL;
            r_in_x   <= w_in_x;
            r_in_y   <= w_in_y;
            r_cx     <= w_cx;
            r_cy     <= w_cy;
            r_primed <= w_primed;
            r_cdone  <= w_cdone;
            r_fcnt   <= w_fcnt;
            r_clken  <= w_clken;
            r_data   <= w_data;
            r_mode   <= w_mode;
            r_wval   <= w_wval;
            r_x      <= w_x;
            r_y      <= w_y;
            r_border <= w_border;
            r_sof    <= w_sof;
            r_busy   <= w_busy;
            r_err    <= w_err;
        end
    end

    assign bus.oCLKEN  = r_clken;
    assign bus.oDATA   = r_data;
    assign bus.oMODE   = r_mode;
    assign bus.oWVAL   = r_wval;
    assign bus.oX      = r_x;
    assign bus.oY      = r_y;
    assign bus.oBORDER = r_border;
    assign bus.oSOF    = r_sof;
    assign bus.oBUSY   = r_busy;
    assign bus.oERR    = r_err;
endmodule

// File: tb/tb_morph_window_ctrl.sv
// Directed vector bench for morph_window_ctrl on a 4x3 frame.
module tb_morph_window_ctrl;
    localparam int H = 4;
    localparam int V = 3;

    logic iCLK   = 1'b0;
    logic iRST_N = 1'b0;

    morph_window_ctrl_if #(.DW(10)) bus ();

    morph_window_ctrl #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .DW       (10),
        .PAD_VALUE(10'h3FF)
    ) dut (
        .iCLK  (iCLK),
        .iRST_N(iRST_N),
        .bus   (bus)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        int fval, dval, din, mode;
        int clken, dout, wval, x, y, bord;
        int sof, busy, err, omode;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ld    = 'h3FF;

    // hand-derived centre order for a 4x3 frame
    int CX[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    int CY[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
    int CB[12] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};

    function automatic vec_t mk(
        input int fv, dv, di, md,
        input int ce, dq, wv, x, y, b,
        input int s, bz, e, om
    );
        vec_t v;
        v.fval = fv; v.dval = dv; v.din = di; v.mode = md;
        v.clken = ce; v.dout = dq; v.wval = wv;
        v.x = x; v.y = y; v.bord = b;
        v.sof = s; v.busy = bz; v.err = e; v.omode = om;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] got %0h required %0h",
                     nm, idx, got, exp);
        end
    endtask

    task automatic drive(input int fv, dv, di, md);
        bus.iFVAL = (fv != 0);
        bus.iDVAL = (dv != 0);
        bus.iDATA = 10'(di);
        bus.iMODE = 2'(md);
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic add_frame(input int mi, input int mo, input int gap);
        int c;
        tbl.push_back(mk(1, 0, 0, mi, 0, ld, 0, 0, 0, 0, 1, 1, 0, mo));
        for (int p = 1; p <= 12; p++) begin
            c = p - 5;
            if (c >= 0)
                tbl.push_back(mk(1, 1, p, 3 - mi, 1, p, 1,
                                 CX[c], CY[c], CB[c], 0, 1, 0, mo));
            else
                tbl.push_back(mk(1, 1, p, 3 - mi, 1, p, 0,
                                 0, 0, 0, 0, 1, 0, mo));
            if (gap != 0 && p < 12)
                tbl.push_back(mk(1, 0, 0, 3 - mi, 0, p, 0,
                                 0, 0, 0, 0, 1, 0, mo));
        end
        for (int f = 0; f < 5; f++) begin
            c = f + 8;
            if (f < 4)
                tbl.push_back(mk(0, 0, 0, 3 - mi, 1, 'h3FF, 1,
                                 CX[c], CY[c], CB[c], 0, 1, 0, mo));
            else
                tbl.push_back(mk(0, 0, 0, 3 - mi, 1, 'h3FF, 0,
                                 0, 0, 0, 0, 0, 0, mo));
        end
        tbl.push_back(mk(0, 0, 0, 0, 0, 'h3FF, 0, 0, 0, 0, 0, 0, 0, mo));
        ld = 'h3FF;
    endtask

    task automatic add_abort();
        tbl.push_back(mk(1, 0, 0, 1, 0, ld, 0, 0, 0, 0, 1, 1, 0, 1));
        for (int p = 1; p <= 6; p++) begin
            if (p == 5)
                tbl.push_back(mk(1, 1, p, 2, 1, p, 1, 0, 0, 1, 0, 1, 0, 1));
            else if (p == 6)
                tbl.push_back(mk(1, 1, p, 2, 1, p, 1, 1, 0, 1, 0, 1, 0, 1));
            else
                tbl.push_back(mk(1, 1, p, 2, 1, p, 0, 0, 0, 0, 0, 1, 0, 1));
        end
        tbl.push_back(mk(0, 0, 0, 2, 0, 6, 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 2, 0, 6, 0, 0, 0, 0, 0, 0, 0, 1));
        ld = 6;
    endtask

    task automatic drive_frame(input int md);
        drive(1, 0, 0, md);
        step();
        for (int p = 1; p <= 12; p++) begin
            drive(1, 1, p, md);
            step();
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_clken"}, 0, int'(bus.oCLKEN), 0);
        chk({nm, "_data"}, 0, int'(bus.oDATA), 'h3FF);
        chk({nm, "_mode"}, 0, int'(bus.oMODE), 0);
        chk({nm, "_wval"}, 0, int'(bus.oWVAL), 0);
        chk({nm, "_x"}, 0, int'(bus.oX), 0);
        chk({nm, "_y"}, 0, int'(bus.oY), 0);
        chk({nm, "_border"}, 0, int'(bus.oBORDER), 0);
        chk({nm, "_sof"}, 0, int'(bus.oSOF), 0);
        chk({nm, "_busy"}, 0, int'(bus.oBUSY), 0);
        chk({nm, "_err"}, 0, int'(bus.oERR), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int pads;
        int errs;
        drive(0, 0, 0, 0);
        iRST_N = 1'b0;
        step();
        step();
        chk_idle("reset");
        iRST_N = 1'b1;
        step();

        add_frame(1, 1, 0);
        add_frame(2, 2, 1);
        add_abort();
        add_frame(3, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].fval, tbl[i].dval, tbl[i].din, tbl[i].mode);
            step();
            chk("clken", i, int'(bus.oCLKEN), tbl[i].clken);
            chk("data", i, int'(bus.oDATA), tbl[i].dout);
            chk("wval", i, int'(bus.oWVAL), tbl[i].wval);
            chk("sof", i, int'(bus.oSOF), tbl[i].sof);
            chk("busy", i, int'(bus.oBUSY), tbl[i].busy);
            chk("err", i, int'(bus.oERR), tbl[i].err);
            chk("mode", i, int'(bus.oMODE), tbl[i].omode);
            if (tbl[i].wval != 0) begin
                chk("x", i, int'(bus.oX), tbl[i].x);
                chk("y", i, int'(bus.oY), tbl[i].y);
                chk("border", i, int'(bus.oBORDER), tbl[i].bord);
            end
        end

        // stray pixel in the middle of the flush
        drive_frame(1);
        pads = 0;
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            drive(0, (i == 1) ? 1 : 0, 'h055, 1);
            step();
            chk("flerr", i, int'(bus.oERR), (i == 1) ? 1 : 0);
            if (bus.oCLKEN) begin
                pads++;
                chk("fldata", i, int'(bus.oDATA), 'h3FF);
            end
            if (bus.oERR) errs++;
        end
        chk("flpads", 0, pads, 5);
        chk("flerrs", 0, errs, 1);
        chk("flbusy", 0, int'(bus.oBUSY), 0);

        // asynchronous reset mid-flush
        drive_frame(2);
        drive(0, 0, 0, 2);
        step();
        step();
        chk("preRst_busy", 0, int'(bus.oBUSY), 1);
        iRST_N = 1'b0;
        #1;
        chk_idle("midrst");
        step();
        iRST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 7, 1);
            step();
            chk("postrst_clken", i, int'(bus.oCLKEN), 0);
            chk("postrst_busy", i, int'(bus.oBUSY), 0);
        end
        drive(1, 0, 0, 1);
        step();
        chk("resof_sof", 0, int'(bus.oSOF), 1);
        chk("resof_busy", 0, int'(bus.oBUSY), 1);
        chk("resof_mode", 0, int'(bus.oMODE), 1);
        chk("resof_clken", 0, int'(bus.oCLKEN), 0);
        drive(1, 1, 9, 1);
        step();
        chk("resof_px_clken", 0, int'(bus.oCLKEN), 1);
        chk("resof_px_data", 0, int'(bus.oDATA), 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
